// File: rtl/mc_maindec_pkg.sv
// Shared encodings for the multicycle MIPS main controller: states, opcodes, ALU ops.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_maindec_if.sv
// Opcode/flag inputs and datapath control outputs of the main decoder.
interface mc_maindec_if;
  logic [5:0] op;
  logic       zero;
  logic [1:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       pcen;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    output op, zero,
    input  aluop, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite,
           regwrite, regdst, memtoreg, pcen, illegal_op, state
  );

  modport slave (
    input  op, zero,
    output aluop, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite,
           regwrite, regdst, memtoreg, pcen, illegal_op, state
  );
endinterface

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM (Moore; pcen and illegal_op also see zero/op).
// state | meaning: FETCH ifetch+PC+4, DECODE reg read/branch tgt, MEMADR addr calc,
// MEMRD/MEMWB load, MEMWR store, RTYPEEX/WB, BEQEX branch, ADDIEX/WB, JEX jump.
module mc_maindec
  import mips_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  mc_maindec_if.slave  ctl
);

  state_e     state_q, state_d;
  logic [1:0] aluop, alusrcb, pcsrc;
  logic       alusrca, iord, irwrite, memwrite, regwrite, regdst, memtoreg;
  logic       pcwrite, branch, illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = S_FETCH;
    aluop    = ALUOP_ADD;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (ctl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        state_d = (ctl.op == OP_SW) ? S_MEMWR : S_MEMRD;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        state_d = S_RTYPEWB;
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        state_d = S_ADDIWB;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by reset_n so an asynchronous abort kills them in the same cycle.
  assign ctl.aluop      = aluop;
  assign ctl.alusrca    = alusrca;
  assign ctl.alusrcb    = alusrcb;
  assign ctl.pcsrc      = pcsrc;
  assign ctl.iord       = iord;
  assign ctl.regdst     = regdst;
  assign ctl.memtoreg   = memtoreg;
  assign ctl.irwrite    = irwrite & reset_n;
  assign ctl.memwrite   = memwrite & reset_n;
  assign ctl.regwrite   = regwrite & reset_n;
  assign ctl.pcen       = (pcwrite | (branch & ctl.zero)) & reset_n;
  assign ctl.illegal_op = illegal & reset_n;
  assign ctl.state      = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Randomized bench for mc_maindec against an instruction-path reference model.
module tb_mc_maindec;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mc_maindec_if dif ();

  mc_maindec dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctl     (dif.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int path_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Visited states for one instruction, starting from fetch.
  task automatic fill_path(input logic [5:0] op);
    path_q = {};
    case (op)
      6'b100011: path_q = '{0, 1, 2, 3, 4};
      6'b101011: path_q = '{0, 1, 2, 5};
      6'b000000: path_q = '{0, 1, 6, 7};
      6'b001000: path_q = '{0, 1, 9, 10};
      6'b000100: path_q = '{0, 1, 8};
      6'b000010: path_q = '{0, 1, 11};
      default:   path_q = '{0, 1};
    endcase
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
  endfunction

  // {aluop, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite, regwrite, regdst, memtoreg}
  function automatic logic [12:0] exp_ctrl(input int st);
    logic [1:0] aluop = 0, srcb = 0, pcsrc = 0;
    logic srca = 0, iord = 0, irw = 0, mw = 0, rw = 0, rd = 0, m2r = 0;
    case (st)
      0:  begin srcb = 2'b01; irw = 1; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; end
      9:  begin srca = 1; srcb = 2'b10; end
      10: rw = 1;
      11: pcsrc = 2'b10;
      default: ;
    endcase
    return {aluop, srca, srcb, pcsrc, iord, irw, mw, rw, rd, m2r};
  endfunction

  function automatic logic [12:0] obs_ctrl();
    return {dif.aluop, dif.alusrca, dif.alusrcb, dif.pcsrc, dif.iord, dif.irwrite,
            dif.memwrite, dif.regwrite, dif.regdst, dif.memtoreg};
  endfunction

  // zmode < 0 drives a random zero flag each cycle; stop_at limits the steps walked.
  task automatic run_instr(input logic [5:0] op, input int zmode, input int stop_at);
    bit z;
    bit exp_pcen;
    dif.op = op;
    fill_path(op);
    foreach (path_q[i]) begin
      if (i >= stop_at) break;
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      dif.zero = z;
      #1;
      exp_pcen = (path_q[i] == 0) || (path_q[i] == 11) || (path_q[i] == 8 && z);
      check_val($sformatf("op%b step%0d state", op, i), 32'(dif.state), 32'(path_q[i]));
      check_val($sformatf("op%b step%0d ctrl", op, i), 32'(obs_ctrl()), 32'(exp_ctrl(path_q[i])));
      check_val($sformatf("op%b step%0d pcen", op, i), 32'(dif.pcen), 32'(exp_pcen));
      check_val($sformatf("op%b step%0d illegal", op, i), 32'(dif.illegal_op),
                32'(path_q[i] == 1 && !is_legal(op)));
      @(negedge clk);
    end
  endtask

  logic [5:0] ops_tab [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
  logic [5:0] rop;

  initial begin
    reset_n  = 1'b0;
    dif.op   = 6'b100011;
    dif.zero = 1'b0;
    #1;
    check_val("rst state", 32'(dif.state), 0);
    check_val("rst irwrite", 32'(dif.irwrite), 0);
    check_val("rst pcen", 32'(dif.pcen), 0);
    check_val("rst regwrite", 32'(dif.regwrite), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    run_instr(6'b100011, -1, 99);
    run_instr(6'b000000, -1, 99);
    run_instr(6'b000100, 1, 99);
    run_instr(6'b000100, 0, 99);
    run_instr(6'b101011, -1, 99);
    run_instr(6'b000010, -1, 99);
    run_instr(6'b111111, -1, 99);
    run_instr(6'b001000, -1, 99);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) rop = 6'($urandom);
      else rop = ops_tab[$urandom_range(0, 5)];
      run_instr(rop, -1, 99);
    end

    // Abort a load during its writeback.
    run_instr(6'b100011, -1, 4);
    #1;
    check_val("memwb state", 32'(dif.state), 4);
    check_val("memwb regwrite", 32'(dif.regwrite), 1);
    #1 reset_n = 1'b0;
    #1;
    check_val("abort state", 32'(dif.state), 0);
    check_val("abort regwrite", 32'(dif.regwrite), 0);
    check_val("abort irwrite", 32'(dif.irwrite), 0);
    check_val("abort pcen", 32'(dif.pcen), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_val("release state", 32'(dif.state), 0);
    check_val("release irwrite", 32'(dif.irwrite), 1);
    run_instr(6'b100011, -1, 99);
    run_instr(6'b000100, -1, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
- Multicycle main control FSM for the MIPS processor; sits directly upstream of the ALU decoder.
- Decodes the instruction opcode over several cycles and sequences the datapath enables, including the 2-bit aluop consumed by the ALU decoder.
- Supports lw, sw, R-type, beq, addi and j; any other opcode returns to fetch and flags illegal_op.

Parameters:
- None. State and opcode encodings are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; rising edge active
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  opcode instr[31:26] from the instruction register; stable from DECODE onward
- zero  in  1  ALU zero flag
- aluop  out  2  to ALU decoder: 00 add, 01 sub, 10 R-type funct
- alusrca  out  1  ALU A select: 0 PC, 1 register A
- alusrcb  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-extended immediate, 11 immediate shifted left 2
- pcsrc  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write
- regdst  out  1  write register select: 0 rt, 1 rd
- memtoreg  out  1  write data select: 0 ALUOut, 1 data register
- pcen  out  1  PC load enable: pcwrite OR (branch AND zero)
- illegal_op  out  1  high in DECODE when op is unsupported
- state  out  4  current state, for debug and bench

Behaviour:
- Moore FSM with one 4-bit state register; all outputs except pcen and illegal_op depend on state only.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Encodings 12-15 are unreachable; if entered, next state is FETCH and outputs are all zero.
- Reset (reset_n low, asynchronous): state=FETCH.
  - While reset_n is low, irwrite, memwrite, regwrite, pcen and illegal_op are forced to 0.
  - First active cycle after release is FETCH.
  - Reset asserted mid-instruction aborts immediately; no partial writes occur after assertion.
- Transitions:
  - FETCH goes to DECODE.
  - DECODE: op 100011 or 101011 to MEMADR; 000000 to RTYPEEX; 000100 to BEQEX; 001000 to ADDIEX; 000010 to JEX; any other op to FETCH with illegal_op=1 for that cycle.
  - MEMADR: lw to MEMRD, sw to MEMWR.
  - MEMRD to MEMWB, then FETCH. MEMWR to FETCH.
  - RTYPEEX to RTYPEWB, then FETCH. BEQEX to FETCH.
  - ADDIEX to ADDIWB, then FETCH. JEX to FETCH.
- Outputs per state (unlisted outputs are 0):
  - FETCH: alusrcb=01, irwrite=1, pcwrite=1
  - DECODE: alusrcb=11
  - MEMADR: alusrca=1, alusrcb=10
  - MEMRD: iord=1
  - MEMWB: memtoreg=1, regwrite=1
  - MEMWR: iord=1, memwrite=1
  - RTYPEEX: alusrca=1, aluop=10
  - RTYPEWB: regdst=1, regwrite=1
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1
  - ADDIEX: alusrca=1, alusrcb=10
  - ADDIWB: regwrite=1
  - JEX: pcsrc=10, pcwrite=1
- pcen is combinational from the internal pcwrite and branch signals and zero; it asserts in BEQEX only when zero=1.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state constants (4-bit)
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
  - aluop constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
- No sub-module inside this block.
- The controller top instantiates mc_maindec alongside the ALU decoder and wires aluop between them.

Test Plan:
- Reset, then release with op=100011 (lw): state sequence 0,1,2,3,4,0. irwrite=1 only in cycle 0; regwrite=1 and memtoreg=1 only in state 4.
- op=000000 (R-type): states 0,1,6,7,0. aluop=10 in state 6; regwrite=1 and regdst=1 in state 7.
- op=000100 (beq), two runs: with zero=1, pcen=1 and pcsrc=01 in state 8; with zero=0, pcen=0 in state 8. Both runs return to FETCH.
- op=101011 (sw) then op=000010 (j): sw path 0,1,2,5 with memwrite=1 and iord=1 in state 5; j path 0,1,11 with pcsrc=10 and pcen=1.
- op=111111 (illegal): illegal_op=1 in DECODE, next state 0; no regwrite or memwrite pulse at any point.
- Pull reset_n low asynchronously while in state 4 (MEMWB): regwrite drops in the same cycle and state reads 0. On release, FETCH runs with irwrite=1.
